// File: rtl/gate_pkg.sv
// Shared types and constants for the gate command sequencer: command codes,
// the six-step sector-to-gates table, the byte check function and FSM states.
package gate_pkg;

  typedef enum logic [1:0] {
    CMD_OFF    = 2'b00,
    CMD_SECTOR = 2'b01,
    CMD_KILL   = 2'b10,
    CMD_INV    = 2'b11
  } cmd_e;

  typedef enum logic {
    HOLD = 1'b0,
    DEAD = 1'b1
  } state_e;

  // Gate bit order is {g3_b,g3_a,g2_b,g2_a,g1_b,g1_a}; entry [k] is sector k.
  localparam logic [5:0][5:0] SECTOR_GATES = {
    6'b011000,  // 5: g3_a + g2_b
    6'b010010,  // 4: g3_a + g1_b
    6'b000110,  // 3: g2_a + g1_b
    6'b100100,  // 2: g2_a + g3_b
    6'b100001,  // 1: g1_a + g3_b
    6'b001001   // 0: g1_a + g2_b
  };

  // Byte layout is {d[4:0], c[2:0]}; detect-only check, no correction.
  function automatic logic ecc_ok(input logic [7:0] b);
    logic [4:0] d;
    logic [2:0] c;
    d = b[7:3];
    c = b[2:0];
    return c == {d[1] ^ d[2] ^ d[3] ^ d[4], d[0] ^ d[2] ^ d[4], d[0] ^ d[1] ^ d[3]};
  endfunction

endpackage

// File: rtl/gate_cmd_sequencer_shoot_sync.sv
// Two-flop synchronizer for the asynchronous shoot line plus a one-cycle
// rising-edge pulse taken from the synchronized level.
module shoot_sync (
  input  logic clk,
  input  logic reset,
  input  logic shoot,
  output logic rise
);

  logic meta_q, sync_q, sync_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      sync_d_q <= 1'b0;
    end else begin
      meta_q   <= shoot;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
    end
  end

  assign rise = sync_q & ~sync_d_q;

endmodule

// File: rtl/gate_cmd_sequencer.sv
// Checks received gate command bytes, holds the decoded pattern as pending and
// applies it on a shoot edge behind an all-off dead time.
// Optional watchdog forcing gates off after inactivity: define GATE_WATCHDOG_EN.
module gate_cmd_sequencer
  import gate_pkg::*;
#(
  parameter int DEAD_CYCLES = 48,
`ifdef GATE_WATCHDOG_EN
  parameter int WDT_CYCLES  = 480000,
`endif
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             parity_error,
  input  logic             shoot,
  output logic [5:0]       gates,
  output logic             pending_valid,
  output logic             busy,
  output logic             cmd_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              rise;
  logic              wdt_fire;
  state_e            state, state_n;
  logic [5:0]        current, current_n, target, target_n, pend_pat, pend_pat_n;
  logic [5:0]        gates_n;
  logic              pend_vld_n, busy_n, cmd_err_n;
  logic [CNT_W-1:0]  err_cnt_n;
  logic [DEAD_W-1:0] dead_cnt, dead_cnt_n;

  shoot_sync u_shoot_sync (
    .clk   (clk),
    .reset (reset),
    .shoot (shoot),
    .rise  (rise)
  );

  // p0: byte decode
  cmd_e       cmd_p0;
  logic [2:0] sec_p0;
  logic [5:0] load_pat_p0;
  logic       bad_cmd_p0, rej_p0, kill_p0;

  assign cmd_p0 = cmd_e'(rx_data[7:6]);
  assign sec_p0 = rx_data[5:3];

  always_comb begin
    load_pat_p0 = '0;
    bad_cmd_p0  = 1'b0;
    case (cmd_p0)
      CMD_OFF:    load_pat_p0 = '0;
      CMD_SECTOR: begin
        if (sec_p0 < 3'd6) load_pat_p0 = SECTOR_GATES[sec_p0];
        else               bad_cmd_p0  = 1'b1;
      end
      CMD_KILL:   load_pat_p0 = '0;
      default:    bad_cmd_p0  = 1'b1;
    endcase
  end

  assign rej_p0  = parity_error | ~ecc_ok(rx_data) | bad_cmd_p0;
  assign kill_p0 = (cmd_p0 == CMD_KILL) & ~rej_p0;

`ifdef GATE_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        wdt_cnt <= '0;
    else if (rise || (rx_done && kill_p0)) wdt_cnt <= WDT_W'(WDT_CYCLES);
    else if (wdt_cnt != '0)           wdt_cnt <= wdt_cnt - 1'b1;
  end

  // A shoot edge in the same cycle wins so the edge handling is not torn apart.
  assign wdt_fire = (state == HOLD) && (wdt_cnt == '0) && (current != '0) && !rise;
`else
  assign wdt_fire = 1'b0;
`endif

  // Order matters: shoot consumes the old pending before a same-cycle byte lands.
  always_comb begin
    state_n    = state;
    gates_n    = gates;
    current_n  = current;
    target_n   = target;
    pend_pat_n = pend_pat;
    pend_vld_n = pending_valid;
    busy_n     = busy;
    dead_cnt_n = dead_cnt;
    cmd_err_n  = 1'b0;
    err_cnt_n  = err_cnt;

    if (state == HOLD) begin
      if (rise && pending_valid) begin
        pend_vld_n = 1'b0;
        if (pend_pat != current) begin
          gates_n    = '0;
          busy_n     = 1'b1;
          dead_cnt_n = DEAD_W'(DEAD_CYCLES);
          target_n   = pend_pat;
          state_n    = DEAD;
        end
      end
    end else begin
      if (dead_cnt == DEAD_W'(1)) begin
        gates_n   = target;
        current_n = target;
        busy_n    = 1'b0;
        state_n   = HOLD;
      end else begin
        dead_cnt_n = dead_cnt - DEAD_W'(1);
      end
    end

    if (wdt_fire) begin
      gates_n    = '0;
      current_n  = '0;
      pend_vld_n = 1'b0;
      cmd_err_n  = 1'b1;
    end

    if (rx_done) begin
      if (rej_p0) begin
        cmd_err_n = 1'b1;
        err_cnt_n = sat_inc(err_cnt);
      end else if (kill_p0) begin
        gates_n    = '0;
        current_n  = '0;
        pend_vld_n = 1'b0;
        busy_n     = 1'b0;
        dead_cnt_n = '0;
        state_n    = HOLD;
      end else begin
        pend_pat_n = load_pat_p0;
        pend_vld_n = 1'b1;
      end
    end
  end

  // p1: registered state and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= HOLD;
      gates         <= '0;
      current       <= '0;
      target        <= '0;
      pend_pat      <= '0;
      pending_valid <= 1'b0;
      busy          <= 1'b0;
      dead_cnt      <= '0;
      cmd_err       <= 1'b0;
      err_cnt       <= '0;
    end else begin
      state         <= state_n;
      gates         <= gates_n;
      current       <= current_n;
      target        <= target_n;
      pend_pat      <= pend_pat_n;
      pending_valid <= pend_vld_n;
      busy          <= busy_n;
      dead_cnt      <= dead_cnt_n;
      cmd_err       <= cmd_err_n;
      err_cnt       <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_gate_cmd_sequencer.sv
// Directed bench for gate_cmd_sequencer: byte checking, dead time, immediate
// off, shoot/byte collisions, error counter saturation and reset behaviour.
module tb_gate_cmd_sequencer;

  localparam int DEAD = 48;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       parity_error = 1'b0;
  logic       shoot = 1'b0;
  logic [5:0] gates;
  logic       pending_valid, busy, cmd_err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gate_cmd_sequencer #(
    .DEAD_CYCLES (DEAD),
`ifdef GATE_WATCHDOG_EN
    .WDT_CYCLES  (1000),
`endif
    .CNT_W       (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .shoot         (shoot),
    .gates         (gates),
    .pending_valid (pending_valid),
    .busy          (busy),
    .cmd_err       (cmd_err),
    .err_cnt       (err_cnt)
  );

  // Advance n cycles, checking phase exclusivity at every sample point.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if ((gates[0] & gates[1]) | (gates[2] & gates[3]) | (gates[4] & gates[5])) begin
        n_fail++;
        $display("FAIL phase_overlap: got gates=%b required no a/b pair high", gates);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr);
    rx_data = b;
    parity_error = perr;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    parity_error = 1'b0;
  endtask

  // Returns at the sample point after the edge pulse has been consumed.
  task automatic fire_shoot(output logic [5:0] pre);
    shoot = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pre = gates;
    @(negedge clk);
    shoot = 1'b0;
  endtask

  task automatic measure_dead(output int n, output logic bad);
    n = 0;
    bad = 1'b0;
    while (busy === 1'b1 && n < 4 * DEAD) begin
      if (gates !== 6'b000000) bad = 1'b1;
      n++;
      tick(1);
    end
  endtask

  task automatic test_reset();
    tick(3);
    n_checks++;
    if ({gates, pending_valid, busy, cmd_err, err_cnt} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gates=%b pv=%b busy=%b err=%b cnt=%0d required all 0",
               gates, pending_valid, busy, cmd_err, err_cnt);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_sector0();
    logic [5:0] pre;
    int n;
    logic bad;
    send_byte(8'h45, 1'b0);
    n_checks++;
    if (pending_valid !== 1'b1 || cmd_err !== 1'b0 || gates !== 6'b000000) begin
      n_fail++;
      $display("FAIL s0_load: got pv=%b err=%b gates=%b required 1 0 000000", pending_valid, cmd_err, gates);
    end
    tick(3);
    fire_shoot(pre);
    n_checks++;
    if (busy !== 1'b1 || pending_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL s0_enter_dead: got busy=%b pv=%b required 1 0", busy, pending_valid);
    end
    measure_dead(n, bad);
    n_checks++;
    if (n != DEAD || bad) begin
      n_fail++;
      $display("FAIL s0_dead_len: got %0d cycles (gates nonzero=%b) required %0d, 0", n, bad, DEAD);
    end
    n_checks++;
    if (gates !== 6'b001001) begin
      n_fail++;
      $display("FAIL s0_gates: got %b required 001001", gates);
    end
  endtask

  task automatic test_change();
    logic [5:0] pre;
    int n;
    logic bad;
    send_byte(8'h50, 1'b0);
    tick(2);
    fire_shoot(pre);
    n_checks++;
    if (pre !== 6'b001001) begin
      n_fail++;
      $display("FAIL chg_pre: got %b required 001001", pre);
    end
    n_checks++;
    if (gates !== 6'b000000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL chg_off: got gates=%b busy=%b required 000000 1", gates, busy);
    end
    measure_dead(n, bad);
    n_checks++;
    if (n != DEAD || bad) begin
      n_fail++;
      $display("FAIL chg_busy_len: got %0d (bad=%b) required %0d", n, bad, DEAD);
    end
    n_checks++;
    if (gates !== 6'b100100) begin
      n_fail++;
      $display("FAIL chg_gates: got %b required 100100", gates);
    end
  endtask

  task automatic test_reject();
    logic [7:0] bad_bytes [4] = '{8'h44, 8'h45, 8'h76, 8'hC3};
    logic [5:0] pre;
    int n;
    logic bad;
    send_byte(8'h45, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(bad_bytes[i], (i == 1));
      n_checks++;
      if (cmd_err !== 1'b1 || err_cnt !== 8'(i + 1) || pending_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rej_%0d: got err=%b cnt=%0d pv=%b required 1 %0d 1", i, cmd_err, err_cnt, pending_valid, i + 1);
      end
    end
    tick(1);
    n_checks++;
    if (cmd_err !== 1'b0 || gates !== 6'b100100) begin
      n_fail++;
      $display("FAIL rej_pulse_end: got err=%b gates=%b required 0 100100", cmd_err, gates);
    end
    for (int i = 0; i < 251; i++) send_byte(8'h44, 1'b0);
    n_checks++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL rej_cnt255: got %0d required 255", err_cnt);
    end
    send_byte(8'h44, 1'b0);
    n_checks++;
    if (err_cnt !== 8'd255 || cmd_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rej_saturate: got cnt=%0d err=%b required 255 1", err_cnt, cmd_err);
    end
    tick(2);
    fire_shoot(pre);
    measure_dead(n, bad);
    n_checks++;
    if (gates !== 6'b001001 || n != DEAD) begin
      n_fail++;
      $display("FAIL rej_pending_kept: got gates=%b dead=%0d required 001001 %0d", gates, n, DEAD);
    end
  endtask

  task automatic test_equal_and_idle();
    logic [5:0] pre;
    tick(3);
    fire_shoot(pre);
    n_checks++;
    if (busy !== 1'b0 || gates !== 6'b001001) begin
      n_fail++;
      $display("FAIL idle_edge: got busy=%b gates=%b required 0 001001", busy, gates);
    end
    tick(3);
    send_byte(8'h45, 1'b0);
    tick(2);
    fire_shoot(pre);
    n_checks++;
    if (busy !== 1'b0 || pending_valid !== 1'b0 || gates !== 6'b001001) begin
      n_fail++;
      $display("FAIL equal_edge: got busy=%b pv=%b gates=%b required 0 0 001001", busy, pending_valid, gates);
    end
  endtask

  task automatic test_kill();
    logic [5:0] pre;
    send_byte(8'h50, 1'b0);
    tick(2);
    fire_shoot(pre);
    tick(10);
    send_byte(8'h86, 1'b0);
    n_checks++;
    if (gates !== 6'b000000 || busy !== 1'b0 || pending_valid !== 1'b0 || cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_now: got gates=%b busy=%b pv=%b err=%b required 000000 0 0 0",
               gates, busy, pending_valid, cmd_err);
    end
    tick(2 * DEAD);
    n_checks++;
    if (gates !== 6'b000000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_stays_off: got gates=%b busy=%b required 000000 0", gates, busy);
    end
  endtask

  task automatic test_same_cycle();
    logic [5:0] pre;
    int n;
    logic bad;
    send_byte(8'h45, 1'b0);
    tick(2);
    shoot = 1'b1;
    tick(2);
    rx_data = 8'h50;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    shoot = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || pending_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_state: got busy=%b pv=%b required 1 1", busy, pending_valid);
    end
    measure_dead(n, bad);
    n_checks++;
    if (gates !== 6'b001001 || pending_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_old: got gates=%b pv=%b required 001001 1", gates, pending_valid);
    end
    tick(2);
    fire_shoot(pre);
    measure_dead(n, bad);
    n_checks++;
    if (gates !== 6'b100100) begin
      n_fail++;
      $display("FAIL same_cycle_new: got %b required 100100", gates);
    end
  endtask

  task automatic test_shoot_in_dead();
    logic [5:0] pre;
    int n;
    logic bad;
    send_byte(8'h45, 1'b0);
    tick(2);
    fire_shoot(pre);
    send_byte(8'h50, 1'b0);
    tick(2);
    fire_shoot(pre);
    n_checks++;
    if (busy !== 1'b1 || pending_valid !== 1'b1 || gates !== 6'b000000) begin
      n_fail++;
      $display("FAIL dead_edge_ignored: got busy=%b pv=%b gates=%b required 1 1 000000", busy, pending_valid, gates);
    end
    measure_dead(n, bad);
    n_checks++;
    if (gates !== 6'b001001 || bad || n != DEAD - 6) begin
      n_fail++;
      $display("FAIL dead_edge_target: got gates=%b rest=%0d bad=%b required 001001 %0d 0", gates, n, bad, DEAD - 6);
    end
    tick(2);
    fire_shoot(pre);
    measure_dead(n, bad);
    n_checks++;
    if (gates !== 6'b100100 || n != DEAD) begin
      n_fail++;
      $display("FAIL dead_edge_next: got gates=%b dead=%0d required 100100 %0d", gates, n, DEAD);
    end
  endtask

  task automatic test_off_cmd();
    logic [5:0] pre;
    int n;
    logic bad;
    send_byte(8'h00, 1'b0);
    n_checks++;
    if (pending_valid !== 1'b1 || cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL off_load: got pv=%b err=%b required 1 0", pending_valid, cmd_err);
    end
    tick(2);
    fire_shoot(pre);
    measure_dead(n, bad);
    n_checks++;
    if (gates !== 6'b000000 || n != DEAD) begin
      n_fail++;
      $display("FAIL off_apply: got gates=%b dead=%0d required 000000 %0d", gates, n, DEAD);
    end
  endtask

  task automatic test_reset_mid_dead();
    logic [5:0] pre;
    send_byte(8'h45, 1'b0);
    tick(2);
    fire_shoot(pre);
    tick(5);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({gates, pending_valid, busy, cmd_err, err_cnt} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_mid_dead: got gates=%b pv=%b busy=%b err=%b cnt=%0d required all 0",
               gates, pending_valid, busy, cmd_err, err_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(2 * DEAD);
    n_checks++;
    if (gates !== 6'b000000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_resume: got gates=%b busy=%b required 000000 0", gates, busy);
    end
  endtask

  task automatic test_hold_or_watchdog();
    logic [5:0] pre;
    int k;
    send_byte(8'h45, 1'b0);
    tick(2);
    fire_shoot(pre);
`ifdef GATE_WATCHDOG_EN
    k = 0;
    while (k < 1500) begin
      tick(1);
      k++;
      if (busy === 1'b0 && gates === 6'b000000) break;
    end
    n_checks++;
    if (k < 995 || k > 1005 || cmd_err !== 1'b1 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL watchdog: got off after %0d cycles err=%b cnt=%0d required ~1000 1 0", k, cmd_err, err_cnt);
    end
`else
    k = DEAD + 1500;
    tick(k);
    n_checks++;
    if (gates !== 6'b001001 || cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL gates_hold: got gates=%b err=%b required 001001 0", gates, cmd_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sector0();
    test_change();
    test_reject();
    test_equal_and_idle();
    test_kill();
    test_same_cycle();
    test_shoot_in_dead();
    test_off_cmd();
    test_reset_mid_dead();
    test_hold_or_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
